cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Common-data-bus scheduler for the Tomasulo core. It shares one result bus between the
//  functional units (add, lw, sw, bne) that hold completed results. Each cycle it grants at
//  most one unit, round-robin, and registers that unit's tag/data onto the CDB, which feeds
//  the reservation stations and ROB. It drives cdb_idle to the fetch controller's issue gating.
// PARAMETERS
//  NREQ    4   number of requesting units; index 0=add, 1=lw, 2=sw, 3=bne
//  TAG_W   5   ROB/RS tag width
//  DATA_W  32  result data width
// PORTS
//  clock      in   1             rising-edge clock
//  reset      in   1             synchronous, active-high reset
//  req_valid  in   NREQ          unit i has a result ready
//  req_tag    in   NREQ*TAG_W    unit i tag, slice [i*TAG_W +: TAG_W]
//  req_data   in   NREQ*DATA_W   unit i data, slice [i*DATA_W +: DATA_W]
//  req_ready  out  NREQ          one-hot grant; transfer when req_valid[i] & req_ready[i]
//  cdb_stall  in   1             CDB consumer cannot accept; hold bus, grant nothing
//  flush      in   1             mispredict / pcChange; discard bus contents
//  cdb_valid  out  1             CDB broadcast valid
//  cdb_tag    out  TAG_W         broadcast tag
//  cdb_data   out  DATA_W        broadcast data
//  cdb_src    out  NREQ          one-hot source unit of current broadcast
//  cdb_idle   out  1             no req_valid and no cdb_valid
// BEHAVIOUR
//  - Clocking: one clock, clock. Reset is synchronous and active-high: reset is sampled on
//    the rising edge of clock.
//  - Reset: cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, rr_ptr=NREQ-1 (unit 0 wins first).
//    req_ready is 0 while reset is high.
//  - Grant (combinational): if !reset & !flush & !cdb_stall, req_ready = one-hot of the first
//    req_valid bit found scanning rr_ptr+1, rr_ptr+2, ... mod NREQ. Otherwise req_ready=0.
//    req_ready is never high for a unit whose req_valid is low.
//  - Transfer: on a grant edge, the register stage loads the granted unit's tag/data.
//    cdb_valid=1 and cdb_src=grant one cycle later (latency 1). rr_ptr <= granted index.
//  - No grant and no stall: cdb_valid <= 0; tag/data/src hold their last values.
//  - cdb_stall=1: all CDB outputs hold, including cdb_valid. rr_ptr holds.
//  - flush=1: cdb_valid <= 0 and cdb_src <= 0 next edge. rr_ptr holds. flush beats stall,
//    and reset beats flush.
//  - Requesters keep valid/tag/data stable until granted. The arbiter never drops a granted
//    transfer except on flush/reset in the same cycle, and then no grant is issued.
//  - Back-to-back: a unit may be granted on consecutive cycles only if no other unit is valid.
//  - Fairness: with all NREQ units valid continuously, each unit is granted once per NREQ cycles.
//  - cdb_idle = ~|req_valid & ~cdb_valid (combinational).
// CONFIGURATION
//  CDB_LOAD_PRIORITY_EN defined:
//    - unit 1 (lw) wins whenever req_valid[1] is high, regardless of rr_ptr.
//    - A lw grant does not update rr_ptr. Other units keep their round-robin order among
//      themselves.
//  CDB_LOAD_PRIORITY_EN undefined:
//    - pure round-robin over all NREQ units as above.
// TESTING
//  1 reset high 2 cycles, req_valid=4'b1111 -> req_ready=0 and cdb_valid=0 throughout;
//    first grant after release is unit 0 (req_ready=4'b0001).
//  2 req_valid=4'b1111 held 8 cycles, tags 1..4 -> cdb_tag sequence 1,2,3,4,1,2,3,4 at
//    1-cycle latency; cdb_src follows one-hot.
//  3 unit 2 valid, tag=7, data=32'hDEAD_BEEF -> next cycle cdb_valid=1, cdb_tag=7,
//    cdb_data=DEADBEEF, cdb_src=4'b0100; following cycle cdb_valid=0.
//  4 cdb_stall=1 for 3 cycles while cdb_valid=1 and units 0,3 valid -> outputs frozen,
//    req_ready=0; after release unit 3 is granted next if rr_ptr=2.
//  5 flush during a grant cycle and during a stall -> next cycle cdb_valid=0, no requester
//    sees req_ready=1, rr_ptr unchanged.
//  6 CDB_LOAD_PRIORITY_EN defined, req_valid=4'b1111 with unit 1 held valid -> unit 1
//    granted every cycle; units 0,2,3 are starved only while lw stays valid.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: grants one completed unit per cycle and registers its tag/data.
// Build option CDB_LOAD_PRIORITY_EN: the lw unit (index 1) always wins and leaves the rotation pointer alone.
module cdb_arbiter #(
    parameter int NREQ   = 4,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic [NREQ-1:0]         req_valid_i,
    input  logic [NREQ*TAG_W-1:0]   req_tag_i,
    input  logic [NREQ*DATA_W-1:0]  req_data_i,
    output logic [NREQ-1:0]         req_ready_o,
    input  logic                    cdb_stall_i,
    input  logic                    flush_i,
    output logic                    cdb_valid_o,
    output logic [TAG_W-1:0]        cdb_tag_o,
    output logic [DATA_W-1:0]       cdb_data_o,
    output logic [NREQ-1:0]         cdb_src_o,
    output logic                    cdb_idle_o
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDX_W-1:0]  rr_ptr_q;
    logic              cdb_valid_q;
    logic [TAG_W-1:0]  cdb_tag_q;
    logic [DATA_W-1:0] cdb_data_q;
    logic [NREQ-1:0]   cdb_src_q;

    logic [NREQ-1:0]   grant_d;
    logic [IDX_W-1:0]  grant_idx_d;
    logic [TAG_W-1:0]  sel_tag_d;
    logic [DATA_W-1:0] sel_data_d;
    logic              found_d;
    logic              lw_win_d;

    always_comb begin
        int unsigned idx;
        grant_d     = '0;
        grant_idx_d = rr_ptr_q;
        sel_tag_d   = '0;
        sel_data_d  = '0;
        found_d     = 1'b0;
        lw_win_d    = 1'b0;
        idx         = 0;
        if (!reset_i && !flush_i && !cdb_stall_i) begin
`ifdef CDB_LOAD_PRIORITY_EN
            if (req_valid_i[1]) begin
                found_d     = 1'b1;
                lw_win_d    = 1'b1;
                grant_d[1]  = 1'b1;
                grant_idx_d = IDX_W'(1);
                sel_tag_d   = req_tag_i[TAG_W +: TAG_W];
                sel_data_d  = req_data_i[DATA_W +: DATA_W];
            end
`endif
            // Scan starts just past the last winner so every unit gets its turn.
            for (int k = 1; k <= NREQ; k++) begin
                idx = (int'(rr_ptr_q) + k) % NREQ;
                if (!found_d && req_valid_i[idx]) begin
                    found_d      = 1'b1;
                    grant_d[idx] = 1'b1;
                    grant_idx_d  = IDX_W'(idx);
                    sel_tag_d    = req_tag_i[idx*TAG_W +: TAG_W];
                    sel_data_d   = req_data_i[idx*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rr_ptr_q    <= IDX_W'(NREQ - 1);
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
        end else if (flush_i) begin
            cdb_valid_q <= 1'b0;
            cdb_src_q   <= '0;
        end else if (cdb_stall_i) begin
            cdb_valid_q <= cdb_valid_q;
        end else if (found_d) begin
            cdb_valid_q <= 1'b1;
            cdb_tag_q   <= sel_tag_d;
            cdb_data_q  <= sel_data_d;
            cdb_src_q   <= grant_d;
            if (!lw_win_d) begin
                rr_ptr_q <= grant_idx_d;
            end
        end else begin
            cdb_valid_q <= 1'b0;
        end
    end

    assign req_ready_o = grant_d;
    assign cdb_valid_o = cdb_valid_q;
    assign cdb_tag_o   = cdb_tag_q;
    assign cdb_data_o  = cdb_data_q;
    assign cdb_src_o   = cdb_src_q;
    assign cdb_idle_o  = ~|req_valid_i & ~cdb_valid_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table, hand sequences and a randomized run
// against a cycle-level reference model.
module tb_cdb_arbiter;
    localparam int NREQ = 4;
    localparam int TAG_W = 5;
    localparam int DATA_W = 32;
`ifdef CDB_LOAD_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*TAG_W-1:0]  req_tag;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   stall, flush;
    logic                   cdb_valid;
    logic [TAG_W-1:0]       cdb_tag;
    logic [DATA_W-1:0]      cdb_data;
    logic [NREQ-1:0]        cdb_src;
    logic                   cdb_idle;

    logic [TAG_W-1:0]  tag_a  [NREQ];
    logic [DATA_W-1:0] data_a [NREQ];

    int tests = 0;
    int failed = 0;

    // reference model state
    bit               m_known = 1'b0;
    logic             m_valid;
    logic [TAG_W-1:0] m_tag;
    logic [31:0]      m_data;
    logic [3:0]       m_src;
    int               m_ptr;
    logic [3:0]       ready_seen;

    always #5 clk = ~clk;

    always_comb begin
        req_tag  = '0;
        req_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_tag[i*TAG_W +: TAG_W]    = tag_a[i];
            req_data[i*DATA_W +: DATA_W] = data_a[i];
        end
    end

    cdb_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clock_i     (clk),
        .reset_i     (rst),
        .req_valid_i (req_valid),
        .req_tag_i   (req_tag),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .cdb_stall_i (stall),
        .flush_i     (flush),
        .cdb_valid_o (cdb_valid),
        .cdb_tag_o   (cdb_tag),
        .cdb_data_o  (cdb_data),
        .cdb_src_o   (cdb_src),
        .cdb_idle_o  (cdb_idle)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] mdl_grant(input logic [3:0] v, input int ptr,
                                            input logic r, input logic f, input logic s);
        if (r || f || s) return 4'b0000;
        if (PRIO && v[1]) return 4'b0010;
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return 4'(1 << ((ptr + k) % NREQ));
        end
        return 4'b0000;
    endfunction

    // One clock cycle: drive, check combinational outputs, clock, advance the model, check registers.
    task automatic step(input logic r, input logic [3:0] v, input logic s, input logic f);
        logic [3:0] g;
        int idx;
        rst = r; req_valid = v; stall = s; flush = f;
        #1;
        g = mdl_grant(v, m_ptr, r, f, s);
        ready_seen = req_ready;
        chk("req_ready", req_ready, g);
        chk("ready_subset_valid", req_ready & ~v, 0);
        if (m_known) chk("cdb_idle", cdb_idle, ~|v & ~m_valid);
        @(posedge clk);
        if (r) begin
            m_known = 1'b1; m_valid = 0; m_tag = 0; m_data = 0; m_src = 0; m_ptr = NREQ - 1;
        end else if (f) begin
            m_valid = 0; m_src = 0;
        end else if (s) begin
            m_valid = m_valid;
        end else if (g != 0) begin
            idx = 0;
            for (int i = 0; i < NREQ; i++) if (g[i]) idx = i;
            m_valid = 1; m_tag = tag_a[idx]; m_data = data_a[idx]; m_src = g;
            if (!(PRIO && idx == 1)) m_ptr = idx;
        end else begin
            m_valid = 0;
        end
        #1;
        if (m_known) begin
            chk("cdb_valid", cdb_valid, m_valid);
            chk("cdb_tag", cdb_tag, m_tag);
            chk("cdb_data", cdb_data, m_data);
            chk("cdb_src", cdb_src, m_src);
        end
    endtask

    typedef struct {
        logic       r;
        logic [3:0] v;
        logic       s;
        logic       f;
        logic [3:0] rdy;
        logic       vld;
        logic [4:0] tag;
        logic [3:0] src;
    } vec_t;

    initial begin
        logic [3:0] pend;
        logic       r, s, f;
`ifndef CDB_LOAD_PRIORITY_EN
        vec_t tbl [20];
`endif
        rst = 1'b1; req_valid = '0; stall = 1'b0; flush = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            tag_a[i]  = TAG_W'(i + 1);
            data_a[i] = 32'h1000 + i;
        end
        @(posedge clk); #1;

`ifndef CDB_LOAD_PRIORITY_EN
        //          r  v        s  f  rdy      vld tag src
        tbl[0]  = '{1, 4'b1111, 0, 0, 4'b0000, 0, 0, 4'b0000};
        tbl[1]  = '{1, 4'b1111, 0, 0, 4'b0000, 0, 0, 4'b0000};
        tbl[2]  = '{0, 4'b1111, 0, 0, 4'b0001, 1, 1, 4'b0001};
        tbl[3]  = '{0, 4'b1111, 0, 0, 4'b0010, 1, 2, 4'b0010};
        tbl[4]  = '{0, 4'b1111, 0, 0, 4'b0100, 1, 3, 4'b0100};
        tbl[5]  = '{0, 4'b1111, 0, 0, 4'b1000, 1, 4, 4'b1000};
        tbl[6]  = '{0, 4'b1111, 0, 0, 4'b0001, 1, 1, 4'b0001};
        tbl[7]  = '{0, 4'b1111, 0, 0, 4'b0010, 1, 2, 4'b0010};
        tbl[8]  = '{0, 4'b1111, 0, 0, 4'b0100, 1, 3, 4'b0100};
        tbl[9]  = '{0, 4'b1111, 0, 0, 4'b1000, 1, 4, 4'b1000};
        tbl[10] = '{0, 4'b0000, 0, 0, 4'b0000, 0, 4, 4'b1000};
        tbl[11] = '{0, 4'b0100, 0, 0, 4'b0100, 1, 3, 4'b0100};
        tbl[12] = '{0, 4'b1001, 1, 0, 4'b0000, 1, 3, 4'b0100};
        tbl[13] = '{0, 4'b1001, 1, 0, 4'b0000, 1, 3, 4'b0100};
        tbl[14] = '{0, 4'b1001, 1, 0, 4'b0000, 1, 3, 4'b0100};
        tbl[15] = '{0, 4'b1001, 0, 0, 4'b1000, 1, 4, 4'b1000};
        tbl[16] = '{0, 4'b1001, 0, 0, 4'b0001, 1, 1, 4'b0001};
        tbl[17] = '{0, 4'b1111, 0, 1, 4'b0000, 0, 1, 4'b0000};
        tbl[18] = '{0, 4'b1111, 1, 1, 4'b0000, 0, 1, 4'b0000};
        tbl[19] = '{0, 4'b1111, 0, 0, 4'b0010, 1, 2, 4'b0010};
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].f);
            chk($sformatf("tbl%0d_ready", i), ready_seen, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), cdb_valid, tbl[i].vld);
            chk($sformatf("tbl%0d_tag", i), cdb_tag, tbl[i].tag);
            chk($sformatf("tbl%0d_src", i), cdb_src, tbl[i].src);
        end
`else
        step(1, 4'b1111, 0, 0);
        step(1, 4'b1111, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 4'b1111, 0, 0);
            chk("lw_prio_ready", ready_seen, 4'b0010);
            chk("lw_prio_tag", cdb_tag, 5'd2);
        end
        step(0, 4'b1101, 0, 0);
        chk("lw_gone_ready", ready_seen, 4'b0001);
        chk("lw_gone_src", cdb_src, 4'b0001);
`endif

        // single unit 2 with a distinctive payload, then bus goes quiet
        tag_a[2] = 5'd7; data_a[2] = 32'hDEAD_BEEF;
        step(0, 4'b0100, 0, 0);
        chk("u2_valid", cdb_valid, 1'b1);
        chk("u2_tag", cdb_tag, 5'd7);
        chk("u2_data", cdb_data, 32'hDEAD_BEEF);
        chk("u2_src", cdb_src, 4'b0100);
        step(0, 4'b0000, 0, 0);
        chk("u2_after_valid", cdb_valid, 1'b0);
        chk("u2_after_tag_hold", cdb_tag, 5'd7);
        chk("idle_quiet", cdb_idle, 1'b1);

        // randomized traffic; requesters hold valid/tag/data until granted
        pend = 4'b0000;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && ($urandom_range(0, 99) < 45)) begin
                    pend[i]   = 1'b1;
                    tag_a[i]  = TAG_W'($urandom);
                    data_a[i] = $urandom;
                end
            end
            r = ($urandom_range(0, 99) < 2);
            f = ($urandom_range(0, 99) < 8);
            s = ($urandom_range(0, 99) < 15);
            step(r, pend, s, f);
            pend = pend & ~ready_seen;
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
